// File: rtl/sel_seq_pkg.sv
// Shared definitions for the SEL sequencer: state codes, counter width and
// default timing parameters.
package sel_seq_pkg;

    localparam int CNT_W        = 8;
    localparam int DEF_RST_HOLD = 10;
    localparam int DEF_GUARD    = 4;

    localparam logic [2:0] ST_HOLD     = 3'd0;
    localparam logic [2:0] ST_RUN      = 3'd1;
    localparam logic [2:0] ST_GATE_OFF = 3'd2;
    localparam logic [2:0] ST_SWITCH   = 3'd3;
    localparam logic [2:0] ST_GATE_ON  = 3'd4;

endpackage

// File: rtl/sel_guard_cnt.sv
// Loadable 8-bit down-counter that stops at 1; expired is high while the count is 1.
// Synchronous reset reloads RST_VAL.
module sel_guard_cnt
    import sel_seq_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = CNT_W'(DEF_RST_HOLD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values; blocking assignments here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != CNT_W'(1)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == CNT_W'(1));

endmodule

// File: rtl/sel_sequencer.sv
// Glitch-safe SEL sequencer: holds downstream reset, then gates the clock for
// GUARD cycles around each SEL change. Define SEL_SEQ_STATUS_EN to add sw_cnt.
module sel_sequencer
    import sel_seq_pkg::*;
#(
    parameter int   RST_HOLD = DEF_RST_HOLD,
    parameter int   GUARD    = DEF_GUARD,
    parameter logic INIT_SEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_sel,
    output logic             req_ready,
    output logic             sel,
    output logic             gate,
    output logic             rst_n_out,
    output logic             done
`ifdef SEL_SEQ_STATUS_EN
    ,
    output logic [CNT_W-1:0] sw_cnt
`endif
);

    localparam logic [CNT_W-1:0] HOLD_V  = CNT_W'(RST_HOLD);
    localparam logic [CNT_W-1:0] GUARD_V = CNT_W'(GUARD);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             sel_latch;
    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_exp;

    assign accept = req_valid && req_ready;

    sel_guard_cnt #(.RST_VAL(HOLD_V)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .expired  (cnt_exp)
    );

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = GUARD_V;
        case (state)
            ST_HOLD:     if (cnt_exp) state_nxt = ST_RUN;
            ST_RUN: begin
                if (accept && (req_sel != sel)) begin
                    state_nxt = ST_GATE_OFF;
                    cnt_load  = 1'b1;
                end
            end
            ST_GATE_OFF: if (cnt_exp) state_nxt = ST_SWITCH;
            ST_SWITCH: begin
                state_nxt = ST_GATE_ON;
                cnt_load  = 1'b1;
            end
            ST_GATE_ON:  if (cnt_exp) state_nxt = ST_RUN;
            default: begin
                state_nxt    = ST_HOLD;
                cnt_load     = 1'b1;
                cnt_load_val = HOLD_V;
            end
        endcase
    end

    // Outputs are registered alongside the state so they change on the same
    // edge as the transition that implies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HOLD;
            sel       <= INIT_SEL;
            sel_latch <= INIT_SEL;
            gate      <= 1'b0;
            rst_n_out <= 1'b0;
            req_ready <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                ST_HOLD: begin
                    if (cnt_exp) begin
                        rst_n_out <= 1'b1;
                        gate      <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (req_sel != sel) begin
                            sel_latch <= req_sel;
                            gate      <= 1'b0;
                            req_ready <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_GATE_OFF: ;
                ST_SWITCH:   sel <= sel_latch;
                ST_GATE_ON: begin
                    if (cnt_exp) begin
                        gate      <= 1'b1;
                        req_ready <= 1'b1;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    gate      <= 1'b0;
                    rst_n_out <= 1'b0;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEL_SEQ_STATUS_EN
    // Counted on completion so a switch aborted by reset never registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_cnt <= '0;
        end else if (state == ST_GATE_ON && cnt_exp) begin
            sw_cnt <= sw_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sel_sequencer.sv
// Directed self-checking bench for sel_sequencer (RST_HOLD=10, GUARD=4, INIT_SEL=1).
// The sw_cnt checks are active when SEL_SEQ_STATUS_EN is defined.
module tb_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_sel = 1'b0;
    logic       req_ready;
    logic       sel;
    logic       gate;
    logic       rst_n_out;
    logic       done;
`ifdef SEL_SEQ_STATUS_EN
    logic [7:0] sw_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sel_sequencer #(.RST_HOLD(10), .GUARD(4), .INIT_SEL(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .sel       (sel),
        .gate      (gate),
        .rst_n_out (rst_n_out),
        .done      (done)
`ifdef SEL_SEQ_STATUS_EN
        ,
        .sw_cnt    (sw_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk the 10 HOLD cycles starting from the first cycle with rst low,
    // then check the first RUN cycle.
    task automatic check_hold(input string tag);
        for (int i = 1; i <= 10; i++) begin
            check({tag, "_hold_rstn"}, 8'(rst_n_out), 8'd0);
            check({tag, "_hold_gate"}, 8'(gate), 8'd0);
            check({tag, "_hold_sel"},  8'(sel), 8'd1);
            check({tag, "_hold_rdy"},  8'(req_ready), 8'd0);
            check({tag, "_hold_done"}, 8'(done), 8'd0);
            tick();
        end
        check({tag, "_run_rstn"}, 8'(rst_n_out), 8'd1);
        check({tag, "_run_gate"}, 8'(gate), 8'd1);
        check({tag, "_run_rdy"},  8'(req_ready), 8'd1);
        check({tag, "_run_sel"},  8'(sel), 8'd1);
        check({tag, "_run_done"}, 8'(done), 8'd0);
    endtask

    // One changing switch with a single-cycle request; done due 10 cycles later.
    task automatic do_switch(input logic v);
        req_valid = 1'b1;
        req_sel   = v;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        check("sw_done", 8'(done), 8'd1);
        check("sw_sel",  8'(sel), 8'(v));
        tick();
    endtask

    initial begin
        int done_cnt;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_sel",  8'(sel), 8'd1);
        check("rst_gate", 8'(gate), 8'd0);
        check("rst_rstn", 8'(rst_n_out), 8'd0);
        check("rst_rdy",  8'(req_ready), 8'd0);
        check("rst_done", 8'(done), 8'd0);
`ifdef SEL_SEQ_STATUS_EN
        check("rst_swcnt", sw_cnt, 8'd0);
`endif

        // Reset release and 10-cycle hold
        rst = 1'b0;
        check_hold("rel");
        tick();

        // Same-value request: done next cycle, nothing else moves
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick();
        req_valid = 1'b0;
        check("same_done", 8'(done), 8'd1);
        check("same_sel",  8'(sel), 8'd1);
        check("same_gate", 8'(gate), 8'd1);
        check("same_rdy",  8'(req_ready), 8'd1);
        tick();
        check("same_done_clr", 8'(done), 8'd0);
        check("same_sel2",     8'(sel), 8'd1);
        check("same_gate2",    8'(gate), 8'd1);

        // Changing request 1->0 accepted at cycle t
        req_valid = 1'b1;
        req_sel   = 1'b0;
        tick();
        req_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            check("chg_gate", 8'(gate), 8'd0);
            check("chg_sel",  8'(sel), (k >= 6) ? 8'd0 : 8'd1);
            check("chg_done", 8'(done), 8'd0);
            check("chg_rdy",  8'(req_ready), 8'd0);
            tick();
        end
        check("chg_done_t10", 8'(done), 8'd1);
        check("chg_gate_t10", 8'(gate), 8'd1);
        check("chg_sel_t10",  8'(sel), 8'd0);
        check("chg_rdy_t10",  8'(req_ready), 8'd1);
        tick();
        check("chg_done_clr", 8'(done), 8'd0);

        // Changing request 0->1 with req_valid toggling while busy
        done_cnt  = 0;
        req_valid = 1'b1;
        req_sel   = 1'b1;
        tick();
        for (int k = 1; k <= 9; k++) begin
            req_valid = k[0];
            req_sel   = ~k[0];
            check("tog_rdy",  8'(req_ready), 8'd0);
            check("tog_gate", 8'(gate), 8'd0);
            if (done) done_cnt++;
            tick();
        end
        req_valid = 1'b0;
        check("tog_done_t10", 8'(done), 8'd1);
        check("tog_sel_t10",  8'(sel), 8'd1);
        check("tog_gate_t10", 8'(gate), 8'd1);
        for (int k = 10; k <= 13; k++) begin
            if (done) done_cnt++;
            check("tog_sel_after", 8'(sel), 8'd1);
            check("tog_rdy_after", 8'(req_ready), 8'd1);
            tick();
        end
        check("tog_done_count", 8'(done_cnt), 8'd1);

        // Reset during SWITCH: abort, no done, full hold follows
        req_valid = 1'b1;
        req_sel   = 1'b0;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        check("abort_in_switch_sel",  8'(sel), 8'd1);
        check("abort_in_switch_gate", 8'(gate), 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_sel",  8'(sel), 8'd1);
        check("abort_gate", 8'(gate), 8'd0);
        check("abort_rstn", 8'(rst_n_out), 8'd0);
        check("abort_done", 8'(done), 8'd0);
        check("abort_rdy",  8'(req_ready), 8'd0);
`ifdef SEL_SEQ_STATUS_EN
        check("abort_swcnt", sw_cnt, 8'd0);
`endif
        check_hold("abort");
        tick();

        // Three changing switches plus one same-value request
        do_switch(1'b0);
        do_switch(1'b1);
        do_switch(1'b0);
        req_valid = 1'b1;
        req_sel   = 1'b0;
        tick();
        req_valid = 1'b0;
        check("cnt_same_done", 8'(done), 8'd1);
        check("cnt_same_sel",  8'(sel), 8'd0);
        tick();
`ifdef SEL_SEQ_STATUS_EN
        check("swcnt_final", sw_cnt, 8'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sel_sequencer.md
SEL_SEQUENCER -- requirements
Module: sel_sequencer

Interface
REQ-001 Parameter RST_HOLD, default 10: cycles RST_N_OUT is held low after reset; legal range 1..255.
REQ-002 Parameter GUARD, default 4: quiet cycles before and after every SEL change; legal range 1..255.
REQ-003 Parameter INIT_SEL, default 1: SEL value driven out of reset.
REQ-004 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 REQ_VALID  input  1  switch request valid.
REQ-007 REQ_SEL  input  1  requested SEL value; sampled only when REQ_VALID and REQ_READY are both high.
REQ-008 REQ_READY  output  1  sequencer can accept a request.
REQ-009 SEL  output  1  registered select to the clock switch and latch-mode flip-flop.
REQ-010 GATE  output  1  downstream clock enable; low while a switch is in progress.
REQ-011 RST_N_OUT  output  1  registered active-low reset to downstream logic.
REQ-012 DONE  output  1  one-cycle pulse when a switch completes.

Function
REQ-013 States: HOLD, RUN, GATE_OFF, SWITCH, GATE_ON.
REQ-014 HOLD drives RST_N_OUT=0 and GATE=0, and lasts exactly RST_HOLD cycles.
- Then enters RUN with RST_N_OUT=1 and GATE=1 in the same cycle.
REQ-015 RUN drives REQ_READY=1; every other state drives REQ_READY=0.
REQ-016 In RUN, a handshake with REQ_SEL != SEL goes to GATE_OFF and latches REQ_SEL.
- GATE drops on the next cycle.
REQ-017 In RUN, a handshake with REQ_SEL == SEL stays in RUN, leaves SEL and GATE unchanged, and pulses DONE on the next cycle.
REQ-018 GATE_OFF holds GATE=0 for GUARD cycles, then moves to SWITCH.
REQ-019 SWITCH lasts one cycle and updates SEL to the latched value; GATE stays 0.
REQ-020 GATE_ON holds GATE=0 for GUARD cycles, then moves to RUN.
- GATE=1 and DONE=1 on the first RUN cycle.
REQ-021 SEL changes only on the SWITCH-to-GATE_ON edge, and GATE is 0 for GUARD cycles on both sides of that edge.
REQ-022 Changed-value request latency: REQ_SEL is accepted in cycle t; DONE is asserted in cycle t+2*GUARD+2.
REQ-023 REQ_VALID while REQ_READY=0 is ignored and not queued; the requester must hold the request until it is accepted.
REQ-024 The guard/hold counter is 8 bits, loads its parameter value on state entry, and counts down to 1.
- Counter wrap-around is unreachable.

Reset
REQ-025 While RST=1, the block forces:
- state=HOLD, SEL=INIT_SEL, GATE=0, RST_N_OUT=0, REQ_READY=0, DONE=0;
- hold counter reloaded to RST_HOLD.
REQ-026 RST asserted mid-switch, in any state, aborts the switch without a DONE pulse, and SEL returns to INIT_SEL.
REQ-027 The RST_HOLD count starts on the first cycle with RST=0.

Configuration
REQ-028 Macro SEL_SEQ_STATUS_EN.
- When defined, the block adds output SW_CNT (8 bits) that counts completed SEL changes. It wraps 255->0, is cleared by RST, and is not incremented by same-value DONE pulses.
- When undefined, the port and its logic are absent, and all other behaviour is identical.

Structure
REQ-029 Shared package sel_seq_pkg holds:
- the state enumeration;
- the counter width constant (8);
- the default RST_HOLD and GUARD values.
REQ-030 One sub-module, sel_guard_cnt, provides the loadable 8-bit down-counter with an expiry flag; it is used for both HOLD and the guard periods.

Verification
REQ-031 Reset release, RST_HOLD=10: RST_N_OUT=0 and GATE=0 for 10 cycles after RST falls, then RST_N_OUT=1, GATE=1, REQ_READY=1; SEL=1 throughout.
REQ-032 GUARD=4, request REQ_SEL=0 accepted at cycle t: the bench checks all of the following.
- GATE=0 over cycles t+1..t+9.
- SEL goes 1->0 at t+6.
- DONE=1 at t+10 with GATE=1.
REQ-033 Request REQ_SEL=1 while SEL=1: DONE pulses one cycle later, and SEL and GATE never change.
REQ-034 REQ_VALID toggling every cycle during GATE_OFF/GATE_ON: no extra switches, REQ_READY stays 0, and exactly one DONE pulse.
REQ-035 RST pulsed during SWITCH: SEL=1, GATE=0, RST_N_OUT=0 on the next cycle; no DONE; full 10-cycle HOLD follows.
REQ-036 With SEL_SEQ_STATUS_EN defined, 3 changing switches plus 1 same-value request give SW_CNT=3.
